cc_multibeat_formatter: RTL and testbench
=========================================

// Module: cc_multibeat_formatter
// PURPOSE
//  Completer Completion (CC) formatter that builds multi-beat completions. It sits between
//  user read logic and the PCIe IP core's s_axis_cc port. A completion request (header fields)
//  and a DATA_WIDTH payload stream go in. DW-aligned beats come out: a 96-bit descriptor
//  followed by the payload, with backpressure-safe output buffering.
// PARAMETERS
//  DATA_WIDTH      256  AXIS width, 256 or 512; K = DATA_WIDTH/32 DWs per beat
//  MAX_PAYLOAD_DW  128  largest legal cc_dword_count (1..1024)
// PORTS
//  user_clk          in   1            clock (IP core user clock)
//  user_reset_n      in   1            synchronous active-low reset
//  cc_req_valid      in   1            completion request valid
//  cc_req_ready      out  1            request accepted when valid&ready
//  cc_requester_id   in   16           from CQ
//  cc_tag            in   8            from CQ
//  cc_tc             in   3            traffic class
//  cc_attr           in   3            attributes
//  cc_lower_addr     in   7            lower address
//  cc_dword_count    in   11           payload DWs N (0 = descriptor only)
//  cc_status         in   3            000 SC, 001 UR, 010 CRS, 100 CA
//  pl_data           in   DATA_WIDTH   payload word, DW0 in bits [31:0]
//  pl_valid          in   1            payload valid
//  pl_ready          out  1            payload accepted when valid&ready
//  cc_len_err        out  1            1-cycle pulse: request had N > MAX_PAYLOAD_DW
//  s_axis_cc_tdata   out  DATA_WIDTH   to IP core
//  s_axis_cc_tvalid  out  1
//  s_axis_cc_tuser   out  33           constant 0
//  s_axis_cc_tkeep   out  K
//  s_axis_cc_tlast   out  1
//  s_axis_cc_tready  in   4            only bit 0 used
// BEHAVIOUR
//  - Reset: FSM=IDLE, tvalid/tlast/cc_len_err=0, tdata/tkeep=0, cc_req_ready=0 during reset.
//  - Descriptor: [6:0] lower_addr, [28:16] byte count = N*4 (13b), [42:32] N, [45:43] status,
//    [63:48] requester_id, [71:64] tag, [91:89] tc, [94:92] attr; all other bits 0.
//  - Beats B = ceil((N+3)/K); payload words W = ceil(N/K); one extra TAIL beat iff B > W.
//  - Beat0 = {pl0[DW-97:0], desc}. Beat k = {pl_k[DW-97:0], pl_{k-1}[DW-1:DW-96]}.
//    The TAIL beat = {0, pl_{W-1}[DW-1:DW-96]}. Bits beyond the final DW are driven 0.
//  - tkeep = all ones, except on the last beat: low ((N+3) mod K, or K when 0) bits set.
//    tlast is set on beat B-1 only.
//  - FSM: IDLE -> (req handshake) FIRST -> BODY* -> TAIL? -> IDLE.
//    N=0 goes IDLE -> FIRST (descriptor only, tkeep=0x7) -> IDLE.
//  - cc_req_ready=1 only in IDLE. Header fields are latched on the handshake.
//    Inputs may change afterwards.
//  - The output register holds tdata/tkeep/tlast/tvalid stable until tready[0]=1.
//    pl_ready = (state in FIRST/BODY) & (~tvalid | tready[0]). One beat per cycle sustained.
//  - A new request is accepted the cycle after the last beat handshakes (1 idle bubble).
//  - Latency: request + pl0 handshake -> beat0 tvalid the next cycle.
//  - N > MAX_PAYLOAD_DW: cc_len_err pulses and no payload is consumed.
//    A descriptor-only completion is sent with status 100 (CA) and N field 0.
//  - Reset mid-packet aborts immediately. tvalid drops, and no partial-packet recovery occurs.
// CONFIGURATION
//  CC_STATS_EN defined: adds outputs stat_cpl_count[31:0] (+1 per tlast handshake) and
//  stat_stall_cycles[31:0] (+1 per cycle tvalid&~tready[0]). Both clear on reset and saturate.
//  Undefined: these ports and counters are absent. Datapath behaviour is identical.
// TESTING (DATA_WIDTH=256, K=8)
//  1) N=1, status SC, tready=1 -> 1 beat, tkeep=0x0F, tlast=1, byte count=4.
//  2) N=5 -> 1 beat, tkeep=0xFF. N=6 -> 2 beats, the second being TAIL with tkeep=0x01 and DW5 in [31:0].
//  3) N=16 -> 3 beats, 2 payload words, last tkeep=0x07. Check realigned DW order 0..15.
//  4) N=32, tready toggled randomly -> tdata/tkeep stable while stalled, no beat lost or duplicated.
//  5) N=0, status UR -> single beat tkeep=0x07, pl_ready never asserted.
//     N=200 -> cc_len_err pulse and CA descriptor.
//  6) Assert reset mid-packet -> tvalid=0 next cycle. A following N=2 completion is correct.
//     With CC_STATS_EN, counters read 0 then 1.

Source files
------------

// File: rtl/cc_multibeat_formatter_if.sv
// Bus bundle for the CC multi-beat formatter: completion request, payload stream
// and the s_axis_cc output toward the PCIe IP core.
interface cc_multibeat_formatter_if #(
  parameter int DATA_WIDTH = 256
);
  localparam int K = DATA_WIDTH / 32;

  logic                  cc_req_valid;
  logic                  cc_req_ready;
  logic [15:0]           cc_requester_id;
  logic [7:0]            cc_tag;
  logic [2:0]            cc_tc;
  logic [2:0]            cc_attr;
  logic [6:0]            cc_lower_addr;
  logic [10:0]           cc_dword_count;
  logic [2:0]            cc_status;
  logic [DATA_WIDTH-1:0] pl_data;
  logic                  pl_valid;
  logic                  pl_ready;
  logic                  cc_len_err;
  logic [DATA_WIDTH-1:0] s_axis_cc_tdata;
  logic                  s_axis_cc_tvalid;
  logic [32:0]           s_axis_cc_tuser;
  logic [K-1:0]          s_axis_cc_tkeep;
  logic                  s_axis_cc_tlast;
  logic [3:0]            s_axis_cc_tready;

  // User read logic / IP-core side
  modport master (
    output cc_req_valid, cc_requester_id, cc_tag, cc_tc, cc_attr, cc_lower_addr,
           cc_dword_count, cc_status, pl_data, pl_valid, s_axis_cc_tready,
    input  cc_req_ready, pl_ready, cc_len_err, s_axis_cc_tdata, s_axis_cc_tvalid,
           s_axis_cc_tuser, s_axis_cc_tkeep, s_axis_cc_tlast
  );

  // Formatter side
  modport slave (
    input  cc_req_valid, cc_requester_id, cc_tag, cc_tc, cc_attr, cc_lower_addr,
           cc_dword_count, cc_status, pl_data, pl_valid, s_axis_cc_tready,
    output cc_req_ready, pl_ready, cc_len_err, s_axis_cc_tdata, s_axis_cc_tvalid,
           s_axis_cc_tuser, s_axis_cc_tkeep, s_axis_cc_tlast
  );
endinterface

// File: rtl/cc_multibeat_formatter.sv
// Completer Completion formatter: 96-bit descriptor + DW-realigned payload beats.
// Optional CC_STATS_EN adds saturating completion/stall counters.
module cc_multibeat_formatter #(
  parameter int DATA_WIDTH     = 256,
  parameter int MAX_PAYLOAD_DW = 128
) (
  input  logic user_clk,
  input  logic user_reset_n,
  cc_multibeat_formatter_if.slave bus
`ifdef CC_STATS_EN
  ,
  output logic [31:0] stat_cpl_count,
  output logic [31:0] stat_stall_cycles
`endif
);
  localparam int K    = DATA_WIDTH / 32;
  localparam int LOGK = $clog2(K);
  localparam int KW   = LOGK + 1;
  localparam int LW   = DATA_WIDTH - 96;

  typedef enum logic [1:0] {IDLE, FIRST, BODY, TAIL} state_t;
  state_t state_reg, state_next;

  logic [15:0]           rid_reg;
  logic [7:0]            tag_reg;
  logic [2:0]            tc_reg;
  logic [2:0]            attr_reg;
  logic [2:0]            status_reg;
  logic [6:0]            laddr_reg;
  logic [10:0]           n_reg;
  logic [11:0]           words_left_reg, words_left_next;
  logic                  tail_reg;
  logic [KW-1:0]         last_cnt_reg;
  logic [95:0]           prev_hi_reg, prev_hi_next;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [K-1:0]          out_keep_reg;
  logic                  out_last_reg;
  logic                  out_valid_reg;
  logic                  len_err_reg;

  logic                  req_ready, req_fire, len_bad, pl_ready, pl_fire, out_free;
  logic [10:0]           eff_n;
  logic [11:0]           n_plus3, eff_words, eff_beats;
  logic [KW-1:0]         eff_cnt;
  logic [95:0]           desc;
  logic                  load, ld_last;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [K-1:0]          last_keep;
  logic [DATA_WIDTH-1:0] last_mask;
  logic                  unused_tready;

  assign unused_tready = ^bus.s_axis_cc_tready[3:1];

  // Oversized requests collapse to a descriptor-only CA completion
  assign len_bad   = bus.cc_dword_count > 11'(MAX_PAYLOAD_DW);
  assign eff_n     = len_bad ? 11'd0 : bus.cc_dword_count;
  assign n_plus3   = {1'b0, eff_n} + 12'd3;
  assign eff_words = ({1'b0, eff_n} + 12'(K - 1)) >> LOGK;
  assign eff_beats = (n_plus3 + 12'(K - 1)) >> LOGK;
  assign eff_cnt   = (n_plus3[LOGK-1:0] == '0) ? KW'(K) : {1'b0, n_plus3[LOGK-1:0]};

  assign out_free  = ~out_valid_reg | bus.s_axis_cc_tready[0];
  assign req_ready = user_reset_n & (state_reg == IDLE) & ~out_valid_reg;
  assign req_fire  = bus.cc_req_valid & req_ready;
  assign pl_ready  = user_reset_n & out_free &
                     (((state_reg == FIRST) && (n_reg != 11'd0)) || (state_reg == BODY));
  assign pl_fire   = bus.pl_valid & pl_ready;

  always_comb begin
    desc          = '0;
    desc[6:0]     = laddr_reg;
    desc[28:16]   = {n_reg, 2'b00};
    desc[42:32]   = n_reg;
    desc[45:43]   = status_reg;
    desc[63:48]   = rid_reg;
    desc[71:64]   = tag_reg;
    desc[91:89]   = tc_reg;
    desc[94:92]   = attr_reg;
  end

  // Last-beat byte enables and matching data mask
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_keep
      assign last_keep[gi]           = KW'(gi) < last_cnt_reg;
      assign last_mask[gi*32 +: 32]  = {32{last_keep[gi]}};
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    load            = 1'b0;
    ld_last         = 1'b0;
    ld_data         = '0;
    words_left_next = words_left_reg;
    prev_hi_next    = prev_hi_reg;
    case (state_reg)
      IDLE: begin
        if (req_fire) state_next = FIRST;
      end
      FIRST, BODY: begin
        if ((state_reg == FIRST) && (n_reg == 11'd0)) begin
          if (out_free) begin
            load       = 1'b1;
            ld_data    = {{LW{1'b0}}, desc};
            ld_last    = 1'b1;
            state_next = IDLE;
          end
        end else if (pl_fire) begin
          load            = 1'b1;
          ld_data         = {bus.pl_data[LW-1:0], (state_reg == FIRST) ? desc : prev_hi_reg};
          prev_hi_next    = bus.pl_data[DATA_WIDTH-1 -: 96];
          words_left_next = words_left_reg - 12'd1;
          if (words_left_reg == 12'd1) begin
            if (tail_reg) begin
              state_next = TAIL;
            end else begin
              ld_last    = 1'b1;
              state_next = IDLE;
            end
          end else begin
            state_next = BODY;
          end
        end
      end
      TAIL: begin
        if (out_free) begin
          load       = 1'b1;
          ld_data    = {{LW{1'b0}}, prev_hi_reg};
          ld_last    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      rid_reg        <= '0;
      tag_reg        <= '0;
      tc_reg         <= '0;
      attr_reg       <= '0;
      status_reg     <= '0;
      laddr_reg      <= '0;
      n_reg          <= '0;
      words_left_reg <= '0;
      tail_reg       <= 1'b0;
      last_cnt_reg   <= '0;
      prev_hi_reg    <= '0;
      len_err_reg    <= 1'b0;
    end else begin
      len_err_reg    <= req_fire & len_bad;
      words_left_reg <= words_left_next;
      prev_hi_reg    <= prev_hi_next;
      if (req_fire) begin
        rid_reg        <= bus.cc_requester_id;
        tag_reg        <= bus.cc_tag;
        tc_reg         <= bus.cc_tc;
        attr_reg       <= bus.cc_attr;
        status_reg     <= len_bad ? 3'b100 : bus.cc_status;
        laddr_reg      <= bus.cc_lower_addr;
        n_reg          <= eff_n;
        words_left_reg <= eff_words;
        tail_reg       <= eff_beats > eff_words;
        last_cnt_reg   <= eff_cnt;
      end
    end
  end

  // Output register: only reloaded when empty or draining this cycle
  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      out_data_reg  <= '0;
      out_keep_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (load) begin
      out_data_reg  <= ld_last ? (ld_data & last_mask) : ld_data;
      out_keep_reg  <= ld_last ? last_keep : '1;
      out_last_reg  <= ld_last;
      out_valid_reg <= 1'b1;
    end else if (bus.s_axis_cc_tready[0]) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.cc_req_ready     = req_ready;
  assign bus.pl_ready         = pl_ready;
  assign bus.cc_len_err       = len_err_reg;
  assign bus.s_axis_cc_tdata  = out_data_reg;
  assign bus.s_axis_cc_tvalid = out_valid_reg;
  assign bus.s_axis_cc_tuser  = '0;
  assign bus.s_axis_cc_tkeep  = out_keep_reg;
  assign bus.s_axis_cc_tlast  = out_last_reg;

`ifdef CC_STATS_EN
  logic [31:0] stat_cpl_reg;
  logic [31:0] stat_stall_reg;

  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      stat_cpl_reg   <= '0;
      stat_stall_reg <= '0;
    end else begin
      if (out_valid_reg && bus.s_axis_cc_tready[0] && out_last_reg && (stat_cpl_reg != '1))
        stat_cpl_reg <= stat_cpl_reg + 32'd1;
      if (out_valid_reg && !bus.s_axis_cc_tready[0] && (stat_stall_reg != '1))
        stat_stall_reg <= stat_stall_reg + 32'd1;
    end
  end

  assign stat_cpl_count    = stat_cpl_reg;
  assign stat_stall_cycles = stat_stall_reg;
`else
  // Statistics counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_cc_multibeat_formatter.sv
// Table-driven bench for cc_multibeat_formatter (DATA_WIDTH=256, K=8), plus a
// mid-packet reset sequence.
module tb_cc_multibeat_formatter;
  localparam int DW = 256;
  localparam int K  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cc_multibeat_formatter_if #(.DATA_WIDTH(DW)) bus ();
`ifdef CC_STATS_EN
  logic [31:0] stat_cpl_count;
  logic [31:0] stat_stall_cycles;
`endif

  cc_multibeat_formatter #(.DATA_WIDTH(DW), .MAX_PAYLOAD_DW(128)) dut (
    .user_clk     (clk),
    .user_reset_n (rst_n),
    .bus          (bus)
`ifdef CC_STATS_EN
    ,
    .stat_cpl_count    (stat_cpl_count),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  typedef struct {
    int         n;
    logic [2:0] status;
    bit         rand_ready;
    int         beats;
    logic [7:0] last_keep;
    int         n_field;
    logic [2:0] st_field;
    int         bc;
    int         words;
    int         len_err;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int n, input logic [2:0] st, input bit rr,
                         input int beats, input logic [7:0] keep, input int nf,
                         input logic [2:0] sf, input int bc, input int words, input int err);
    vecs[i].n = n;         vecs[i].status = st;    vecs[i].rand_ready = rr;
    vecs[i].beats = beats; vecs[i].last_keep = keep;
    vecs[i].n_field = nf;  vecs[i].st_field = sf;  vecs[i].bc = bc;
    vecs[i].words = words; vecs[i].len_err = err;
  endtask

  function automatic logic [31:0] pdw(input int seed, input int idx);
    return {8'(seed), 8'hA5, 16'(idx)};
  endfunction

  function automatic logic [95:0] mk_desc(input logic [6:0] la, input logic [12:0] bc,
                                          input logic [10:0] n, input logic [2:0] st,
                                          input logic [15:0] rid, input logic [7:0] tag,
                                          input logic [2:0] tc, input logic [2:0] attr);
    logic [95:0] d;
    d = '0;
    d[6:0] = la;   d[28:16] = bc;  d[42:32] = n;   d[45:43] = st;
    d[63:48] = rid; d[71:64] = tag; d[91:89] = tc; d[94:92] = attr;
    return d;
  endfunction

  // Flat DW stream: descriptor DWs 0..2 followed by payload DWs, zero beyond the end
  function automatic logic [31:0] exp_dw(input logic [95:0] desc, input int n, input int seed,
                                         input int pos);
    if (pos < 3) return desc[pos*32 +: 32];
    if (pos - 3 < n) return pdw(seed, pos - 3);
    return 32'd0;
  endfunction

  task automatic run_cpl(input int vi, input int seed);
    vec_t v;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [2:0]  tc, attr;
    logic [6:0]  la;
    logic [95:0] desc;
    logic [DW-1:0] w, exp_data, held_data;
    logic [7:0] held_keep, exp_keep;
    logic held_last;
    int words_offer, pl_idx, beat, err_seen, plr_seen, cyc, first_pl, first_tv;
    bit req_done, done, held;
    v = vecs[vi];
    rid = 16'hB000 | 16'(vi * 17);
    tag = 8'(8'h40 + vi);
    tc = 3'(vi);
    attr = 3'(vi + 2);
    la = 7'(vi * 9 + 1);
    desc = mk_desc(la, 13'(v.bc), 11'(v.n_field), v.st_field, rid, tag, tc, attr);
    words_offer = (v.n + K - 1) / K;
    pl_idx = 0; beat = 0; err_seen = 0; plr_seen = 0; cyc = 0; first_pl = -1; first_tv = -1;
    req_done = 0; done = 0; held = 0;
    held_data = '0; held_keep = '0; held_last = 1'b0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      if (!req_done) begin
        bus.cc_req_valid = 1'b1;
        bus.cc_requester_id = rid; bus.cc_tag = tag; bus.cc_tc = tc; bus.cc_attr = attr;
        bus.cc_lower_addr = la; bus.cc_dword_count = 11'(v.n); bus.cc_status = v.status;
      end else begin
        bus.cc_req_valid = 1'b0;
        bus.cc_requester_id = 16'($urandom); bus.cc_tag = 8'($urandom);
        bus.cc_dword_count = 11'($urandom); bus.cc_status = 3'($urandom);
      end
      for (int d = 0; d < K; d++) w[d*32 +: 32] = pdw(seed, pl_idx * K + d);
      bus.pl_data = w;
      bus.pl_valid = (pl_idx < words_offer);
      bus.s_axis_cc_tready = {3'($urandom), v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1};
      #1;
      if (bus.cc_len_err) err_seen++;
      if (bus.pl_ready) plr_seen++;
      if (held) begin
        check("hold_valid", 256'(bus.s_axis_cc_tvalid), 256'(1));
        check("hold_data", bus.s_axis_cc_tdata, held_data);
        check("hold_keep", 256'(bus.s_axis_cc_tkeep), 256'(held_keep));
        check("hold_last", 256'(bus.s_axis_cc_tlast), 256'(held_last));
        held = 0;
      end
      if (bus.s_axis_cc_tvalid) begin
        if (first_tv < 0) first_tv = cyc;
        if (bus.s_axis_cc_tready[0]) begin
          for (int d = 0; d < K; d++) exp_data[d*32 +: 32] = exp_dw(desc, v.n_field, seed, beat * K + d);
          exp_keep = (beat == v.beats - 1) ? v.last_keep : 8'hFF;
          check($sformatf("v%0d_b%0d_data", vi, beat), bus.s_axis_cc_tdata, exp_data);
          check($sformatf("v%0d_b%0d_keep", vi, beat), 256'(bus.s_axis_cc_tkeep), 256'(exp_keep));
          check($sformatf("v%0d_b%0d_last", vi, beat), 256'(bus.s_axis_cc_tlast), 256'(beat == v.beats - 1));
          if (beat == 0) begin
            check($sformatf("v%0d_bytecount", vi), 256'(bus.s_axis_cc_tdata[28:16]), 256'(v.bc));
            check($sformatf("v%0d_status", vi), 256'(bus.s_axis_cc_tdata[45:43]), 256'(v.st_field));
          end
          beat++;
          if (bus.s_axis_cc_tlast) done = 1;
        end else begin
          held = 1;
          held_data = bus.s_axis_cc_tdata;
          held_keep = bus.s_axis_cc_tkeep;
          held_last = bus.s_axis_cc_tlast;
        end
      end
      if (!req_done && bus.cc_req_valid && bus.cc_req_ready) req_done = 1;
      if (bus.pl_valid && bus.pl_ready) begin
        if (first_pl < 0) first_pl = cyc;
        pl_idx++;
      end
      cyc++;
    end
    check($sformatf("v%0d_completed", vi), 256'(done), 256'(1));
    check($sformatf("v%0d_beats", vi), 256'(beat), 256'(v.beats));
    check($sformatf("v%0d_len_err", vi), 256'(err_seen), 256'(v.len_err));
    check($sformatf("v%0d_pl_consumed", vi), 256'(pl_idx), 256'(v.words));
    if (v.words == 0) check($sformatf("v%0d_pl_ready_seen", vi), 256'(plr_seen), 256'(0));
    if (!v.rand_ready && v.words > 0)
      check($sformatf("v%0d_latency", vi), 256'(first_tv - first_pl), 256'(1));
    @(negedge clk);
    bus.cc_req_valid = 1'b0;
    bus.pl_valid = 1'b0;
    bus.s_axis_cc_tready = 4'b0001;
    #1;
    check($sformatf("v%0d_post_tvalid", vi), 256'(bus.s_axis_cc_tvalid), 256'(0));
    check($sformatf("v%0d_post_req_ready", vi), 256'(bus.cc_req_ready), 256'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] w;
    bus.cc_req_valid = 1'b0; bus.cc_requester_id = '0; bus.cc_tag = '0; bus.cc_tc = '0;
    bus.cc_attr = '0; bus.cc_lower_addr = '0; bus.cc_dword_count = '0; bus.cc_status = '0;
    bus.pl_data = '0; bus.pl_valid = 1'b0; bus.s_axis_cc_tready = 4'b0001;

    //      i   N    st    rr beats keep   Nf  stf    bc   words err
    set_vec(0,  1,   3'd0, 0, 1,    8'h0F, 1,   3'd0, 4,   1,    0);
    set_vec(1,  5,   3'd0, 0, 1,    8'hFF, 5,   3'd0, 20,  1,    0);
    set_vec(2,  6,   3'd0, 0, 2,    8'h01, 6,   3'd0, 24,  1,    0);
    set_vec(3,  16,  3'd0, 0, 3,    8'h07, 16,  3'd0, 64,  2,    0);
    set_vec(4,  32,  3'd0, 1, 5,    8'h07, 32,  3'd0, 128, 4,    0);
    set_vec(5,  0,   3'd1, 0, 1,    8'h07, 0,   3'd1, 0,   0,    0);
    set_vec(6,  200, 3'd0, 0, 1,    8'h07, 0,   3'd4, 0,   0,    1);
    set_vec(7,  128, 3'd2, 0, 17,   8'h07, 128, 3'd2, 512, 16,   0);
    set_vec(8,  129, 3'd0, 0, 1,    8'h07, 0,   3'd4, 0,   0,    1);
    set_vec(9,  3,   3'd0, 1, 1,    8'h3F, 3,   3'd0, 12,  1,    0);
    set_vec(10, 2,   3'd0, 0, 1,    8'h1F, 2,   3'd0, 8,   1,    0);

    repeat (3) @(negedge clk);
    #1;
    check("rst_tvalid", 256'(bus.s_axis_cc_tvalid), 256'(0));
    check("rst_tlast", 256'(bus.s_axis_cc_tlast), 256'(0));
    check("rst_tkeep", 256'(bus.s_axis_cc_tkeep), 256'(0));
    check("rst_tdata", bus.s_axis_cc_tdata, 256'(0));
    check("rst_len_err", 256'(bus.cc_len_err), 256'(0));
    check("rst_req_ready", 256'(bus.cc_req_ready), 256'(0));
    check("rst_tuser", 256'(bus.s_axis_cc_tuser), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("idle_req_ready", 256'(bus.cc_req_ready), 256'(1));
`ifdef CC_STATS_EN
    check("stat_cpl_after_rst", 256'(stat_cpl_count), 256'(0));
`endif

    for (int i = 0; i < NV - 1; i++) run_cpl(i, i + 1);

    // Mid-packet reset: stall the first beat of an N=32 completion, then reset
    @(negedge clk);
    bus.cc_req_valid = 1'b1; bus.cc_dword_count = 11'd32; bus.cc_status = 3'd0;
    for (int d = 0; d < K; d++) w[d*32 +: 32] = pdw(99, d);
    bus.pl_data = w;
    bus.pl_valid = 1'b1;
    bus.s_axis_cc_tready = 4'b0000;
    repeat (3) @(negedge clk);
    bus.cc_req_valid = 1'b0;
    #1;
    check("midrst_pre_tvalid", 256'(bus.s_axis_cc_tvalid), 256'(1));
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_tvalid", 256'(bus.s_axis_cc_tvalid), 256'(0));
    check("midrst_req_ready", 256'(bus.cc_req_ready), 256'(0));
    check("midrst_pl_ready", 256'(bus.pl_ready), 256'(0));
    bus.pl_valid = 1'b0;
    bus.s_axis_cc_tready = 4'b0001;
    rst_n = 1'b1;
    @(negedge clk);
`ifdef CC_STATS_EN
    #1;
    check("stat_cpl_zero", 256'(stat_cpl_count), 256'(0));
    check("stat_stall_zero", 256'(stat_stall_cycles), 256'(0));
`endif
    run_cpl(NV - 1, NV);
`ifdef CC_STATS_EN
    check("stat_cpl_one", 256'(stat_cpl_count), 256'(1));
    check("stat_stall_none", 256'(stat_stall_cycles), 256'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
